servo_pwm: RTL and testbench
============================

# servo_pwm

Converts the 0–180 degree angle produced by the angle sweep stage into a standard hobby-servo PWM waveform: one pulse per fixed frame, with pulse width linearly mapped from angle. It sits directly downstream of the sweep block, takes its `angle` bus unmodified, and drives the servo signal pin. The angle is sampled once per frame and converted by a sequential shift-subtract divider, so the output never shows a truncated or glitched pulse.

## Interface
- `FRAME_TICKS`, 240000: frame period in clk cycles (20 ms at 12 MHz).
- `MIN_TICKS`, 6000: pulse width at angle 0 (0.5 ms).
- `MAX_TICKS`, 30000: pulse width at angle 180 (2.5 ms).
- `PRESAMPLE`, 64: cycles before frame end at which the angle is sampled.
- Legal parameter range: `MAX_TICKS > MIN_TICKS`, `FRAME_TICKS > MAX_TICKS + PRESAMPLE`, `PRESAMPLE >= 40`.
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high.
- `angle`, input, 8: commanded angle in degrees, from the sweep stage.
- `enable`, input, 1: when 0, frames run but no pulse is emitted.
- `pwm_out`, output, 1: servo signal, registered.
- `frame_start`, output, 1: one-cycle strobe on the first cycle of each frame, registered.
- `angle_clamped`, output, 1: high for the frame whose sampled angle exceeded 180.
- `busy`, output, 1: divider FSM is in CALC.

## Operation
- Frame counter `frame_cnt` runs from 0 to `FRAME_TICKS-1`, then wraps to 0.
- Sample point is the cycle where `frame_cnt == FRAME_TICKS-PRESAMPLE`. On that cycle the block captures:
  - `angle`, clamped to 180;
  - `enable`;
  - a clamp flag, set when `angle > 180`.
- Conversion: `width_next = MIN_TICKS + floor(a*(MAX_TICKS-MIN_TICKS)/180)`.
  - The product is unsigned and 26 bits wide.
  - The divide is a restoring shift-subtract, one quotient bit per cycle.
- FSM states:
  - IDLE: waits for the sample point, then → CALC.
  - CALC: runs one bit per cycle; after the last bit → DONE. Total time is at most 32 cycles.
  - DONE: holds `width_next` until the frame wrap, then → IDLE.
- Commit at wrap, on the edge where `frame_cnt` goes from `FRAME_TICKS-1` to 0:
  - `width_cur <= width_next`;
  - `active <= sampled_enable`;
  - `angle_clamped <=` the sampled clamp flag.
- `pwm_out` is high exactly while `active` is set and `frame_cnt < width_cur`, aligned with `frame_start`.
- Changes to `angle` or `enable` outside the sample cycle have no effect until the next sample point.
- An angle sampled in frame N drives frame N+1.
- If a wrap arrives while the FSM is still in CALC (impossible with legal parameters), the previous `width_cur` and `active` are kept.

## Timing
- Reset values:
  - `pwm_out`=0, `frame_start`=0, `angle_clamped`=0, `busy`=0;
  - `frame_cnt`=0, `active`=0, `width_cur`=`MIN_TICKS`, FSM=IDLE.
- First frame after reset release:
  - `frame_start` pulses on the first cycle after reset deassertion;
  - no pulse is emitted (`active`=0);
  - the first real pulse appears in the second frame.
- Pulse length is exactly `width_cur` cycles, starting in the same cycle as `frame_start`. Frame length is exactly `FRAME_TICKS` cycles.
- `busy` rises the cycle after the sample point and stays high for at most 32 cycles.
- Reset asserted mid-pulse: `pwm_out`=0 from the next edge, and all state returns to reset values.
- Angle 180 gives `MAX_TICKS` (no rounding overshoot); angle 0 gives `MIN_TICKS`.

## Test plan
Bench parameters: `FRAME_TICKS`=2000, `MIN_TICKS`=100, `MAX_TICKS`=280, `PRESAMPLE`=64. These give width = 100 + angle.
- Reset, `angle`=90, `enable`=1 -> frame 0 has no pulse; frame 1 has a 190-cycle pulse starting with `frame_start`; frame period is 2000 cycles.
- Angles 0, 1, 179, 180 in successive frames -> pulse widths 100, 101, 279, 280, each one frame after its sample.
- `angle`=200 -> width 280 and `angle_clamped`=1 for that frame; returning to `angle`=10 -> width 110 and `angle_clamped`=0.
- `angle` changed from 30 to 60 at `frame_cnt`=1950 (after the sample point) -> next frame 130, the frame after that 160.
- `enable` dropped before the sample point -> next frame `pwm_out` stays 0, `frame_start` still pulses; re-enable -> pulses resume one frame later.
- `reset` asserted at `frame_cnt`=50 of a 190-cycle pulse -> `pwm_out`=0 next cycle; after release, the frame restarts with no pulse.

Source files
------------

// File: rtl/servo_pwm.sv
// Hobby-servo PWM generator: one pulse per frame, width mapped linearly from a 0-180 degree angle.
// The angle is sampled near frame end and converted by a serial restoring divider before the wrap.
module servo_pwm #(
  parameter int unsigned FRAME_TICKS = 240000,
  parameter int unsigned MIN_TICKS   = 6000,
  parameter int unsigned MAX_TICKS   = 30000,
  parameter int unsigned PRESAMPLE   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] angle,
  input  logic       enable,
  output logic       pwm_out,
  output logic       frame_start,
  output logic       angle_clamped,
  output logic       busy
);

  localparam int unsigned CNT_W  = $clog2(FRAME_TICKS);
  localparam int unsigned ANG_W  = 8;
  localparam int unsigned PROD_W = 26;
  localparam int unsigned REM_W  = 8;
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned SPAN   = MAX_TICKS - MIN_TICKS;

  localparam logic [ANG_W-1:0] ANGLE_MAX  = ANG_W'(180);
  localparam logic [REM_W:0]   DIVISOR    = (REM_W+1)'(180);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(FRAME_TICKS - PRESAMPLE);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(PROD_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  width_cur;
  logic              active;
  logic              clamp_cur;
  logic              s_en;
  logic              s_clamp;
  logic [PROD_W-1:0] dq;
  logic [REM_W-1:0]  rem;
  logic [BIT_W-1:0]  bit_cnt;

  logic              wrap_c;
  logic              sample_c;
  logic [ANG_W-1:0]  angle_sat_c;
  logic [PROD_W-1:0] prod_c;
  logic [REM_W:0]    rem_sh_c;
  logic              ge_c;
  logic [CNT_W-1:0]  width_next_c;

  // Frame markers, saturated angle and the scaled product fed to the divider
  always_comb begin
    wrap_c       = (frame_cnt == LAST_CNT);
    sample_c     = (frame_cnt == SAMPLE_CNT);
    angle_sat_c  = (angle > ANGLE_MAX) ? ANGLE_MAX : angle;
    prod_c       = PROD_W'(angle_sat_c) * PROD_W'(SPAN);
    rem_sh_c     = {rem, dq[PROD_W-1]};
    ge_c         = (rem_sh_c >= DIVISOR);
    width_next_c = CNT_W'(MIN_TICKS) + CNT_W'(dq);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_c) state_next = CALC;
      CALC:    if (bit_cnt == LAST_BIT) state_next = DONE;
      DONE:    if (wrap_c) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: frame counter, sampling, restoring divider and wrap commit
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt     <= '0;
      width_cur     <= CNT_W'(MIN_TICKS);
      active        <= 1'b0;
      clamp_cur     <= 1'b0;
      s_en          <= 1'b0;
      s_clamp       <= 1'b0;
      dq            <= '0;
      rem           <= '0;
      bit_cnt       <= '0;
      pwm_out       <= 1'b0;
      frame_start   <= 1'b0;
      angle_clamped <= 1'b0;
      busy          <= 1'b0;
    end else begin
      frame_cnt <= wrap_c ? '0 : frame_cnt + CNT_W'(1);

      if (state == IDLE && sample_c) begin
        dq      <= prod_c;
        rem     <= '0;
        bit_cnt <= '0;
        s_en    <= enable;
        s_clamp <= (angle > ANGLE_MAX);
      end else if (state == CALC) begin
        // Dividend shifts out of the top while quotient bits enter at the bottom
        dq      <= {dq[PROD_W-2:0], ge_c};
        rem     <= ge_c ? REM_W'(rem_sh_c - DIVISOR) : rem_sh_c[REM_W-1:0];
        bit_cnt <= bit_cnt + BIT_W'(1);
      end

      // An unfinished conversion at wrap leaves the previous frame settings in place
      if (wrap_c && state == DONE) begin
        width_cur <= width_next_c;
        active    <= s_en;
        clamp_cur <= s_clamp;
      end

      frame_start   <= (frame_cnt == '0);
      pwm_out       <= active && (frame_cnt < width_cur);
      angle_clamped <= clamp_cur;
      busy          <= (state_next == CALC);
    end
  end

endmodule

// File: tb/tb_servo_pwm.sv
// Directed bench for servo_pwm with a reduced frame (2000 cycles, width = 100 + angle).
// Each frame is measured from frame_start to frame_start and compared to hand-computed values.
module tb_servo_pwm;

  localparam int unsigned FT  = 2000;
  localparam int unsigned MNT = 100;
  localparam int unsigned MXT = 280;
  localparam int unsigned PS  = 64;
  localparam int          CALC_CYCLES = 26;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] angle;
  logic       enable;
  logic       pwm_out;
  logic       frame_start;
  logic       angle_clamped;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  servo_pwm #(
    .FRAME_TICKS(FT),
    .MIN_TICKS  (MNT),
    .MAX_TICKS  (MXT),
    .PRESAMPLE  (PS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .angle        (angle),
    .enable       (enable),
    .pwm_out      (pwm_out),
    .frame_start  (frame_start),
    .angle_clamped(angle_clamped),
    .busy         (busy)
  );

  typedef struct {
    logic [7:0] a;
    logic       en;
    int         exp_w;
    logic       exp_clamp;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Wait (bounded) for frame_start; reports how many cycles it took
  task automatic wait_frame_start(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!frame_start && lat < 4000);
  endtask

  // Entered at the negedge where frame_start is high; leaves at the next frame_start
  task automatic run_frame(input string tag, input logic [7:0] a, input logic en,
                           input int chg_at, input logic [7:0] chg_a,
                           input int exp_w, input logic exp_clamp);
    int   cyc = 0;
    int   hi  = 0;
    int   bz  = 0;
    logic first_pwm;
    logic first_clamp;
    angle       = a;
    enable      = en;
    first_pwm   = pwm_out;
    first_clamp = angle_clamped;
    do begin
      if (pwm_out) hi++;
      if (busy) bz++;
      if (cyc == chg_at) angle = chg_a;
      @(negedge clk);
      cyc++;
    end while (!frame_start && cyc < 4000);
    check({tag, " period"}, cyc, int'(FT));
    check({tag, " width"}, hi, exp_w);
    check({tag, " pulse_aligned"}, int'(first_pwm), (exp_w > 0) ? 1 : 0);
    check({tag, " clamped"}, int'(first_clamp), int'(exp_clamp));
    check({tag, " busy_len"}, bz, CALC_CYCLES);
  endtask

  initial begin
    int lat;

    // Inputs applied during frame i; expected width/clamp describe frame i itself
    tbl[0]  = '{8'd90,  1'b1, 0,   1'b0};
    tbl[1]  = '{8'd0,   1'b1, 190, 1'b0};
    tbl[2]  = '{8'd1,   1'b1, 100, 1'b0};
    tbl[3]  = '{8'd179, 1'b1, 101, 1'b0};
    tbl[4]  = '{8'd180, 1'b1, 279, 1'b0};
    tbl[5]  = '{8'd200, 1'b1, 280, 1'b0};
    tbl[6]  = '{8'd10,  1'b1, 280, 1'b1};
    tbl[7]  = '{8'd30,  1'b1, 110, 1'b0};
    tbl[8]  = '{8'd30,  1'b0, 130, 1'b0};
    tbl[9]  = '{8'd30,  1'b1, 0,   1'b0};
    tbl[10] = '{8'd255, 1'b1, 130, 1'b0};
    tbl[11] = '{8'd0,   1'b1, 280, 1'b1};
    tbl[12] = '{8'd30,  1'b1, 100, 1'b0};

    reset  = 1'b1;
    angle  = 8'd90;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("reset pwm_out", int'(pwm_out), 0);
    check("reset frame_start", int'(frame_start), 0);
    check("reset angle_clamped", int'(angle_clamped), 0);
    check("reset busy", int'(busy), 0);

    reset = 1'b0;
    wait_frame_start(lat);
    check("first frame_start latency", lat, 1);

    for (int i = 0; i < 13; i++) begin
      run_frame($sformatf("frame%0d", i), tbl[i].a, tbl[i].en, -1, 8'd0,
                tbl[i].exp_w, tbl[i].exp_clamp);
    end

    // Angle moves 30 -> 60 after the sample point: takes effect one frame later
    run_frame("late_chg f13", 8'd30, 1'b1, 1949, 8'd60, 130, 1'b0);
    run_frame("late_chg f14", 8'd60, 1'b1, -1, 8'd0, 130, 1'b0);
    run_frame("late_chg f15", 8'd90, 1'b1, -1, 8'd0, 160, 1'b0);

    // Now at the start of a 190-cycle pulse; reset at frame_cnt 50
    repeat (50) @(negedge clk);
    check("mid_pulse pwm before reset", int'(pwm_out), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset pwm_out", int'(pwm_out), 0);
    check("mid_reset frame_start", int'(frame_start), 0);
    check("mid_reset busy", int'(busy), 0);
    check("mid_reset angle_clamped", int'(angle_clamped), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_frame_start(lat);
    check("post_reset frame_start latency", lat, 1);
    run_frame("post_reset f0", 8'd90, 1'b1, -1, 8'd0, 0, 1'b0);
    run_frame("post_reset f1", 8'd90, 1'b1, -1, 8'd0, 190, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
